// File: rtl/test_seq_pkg.sv
// Shared types and helpers for the test phase sequencer: FSM state encoding,
// phase-index width helper and result codes.
package test_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_NEXT,
        S_PASS,
        S_FAIL
    } state_t;

    // A single phase still needs a 1-bit index.
    function automatic int phase_w_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam logic [1:0] RES_NONE    = 2'd0;
    localparam logic [1:0] RES_PASS    = 2'd1;
    localparam logic [1:0] RES_FAIL    = 2'd2;
    localparam logic [1:0] RES_TIMEOUT = 2'd3;

endpackage

// File: rtl/test_seq_timer.sv
// Per-phase WAIT timer: counts while enabled, clears on request, flags the
// last allowed cycle of the timeout window.
module test_seq_timer #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/test_phase_sequencer.sv
// Sequences NUM_PHASES test phases (start pulse, timed wait for done) and drives
// sticky pass/fail into the status monitor. Option: TEST_SEQ_CONTINUE_ON_FAIL_EN.
//
// state   | meaning
// IDLE    | waiting for enable
// START   | phase_start pulse for phase_id, timer cleared
// WAIT    | waiting for phase_done under timeout
// NEXT    | advance phase_id, gap cycle between phases
// PASS    | terminal, all phases clean
// FAIL    | terminal, failure recorded in err_phase/timeout
module test_phase_sequencer
    import test_seq_pkg::*;
#(
    parameter int NUM_PHASES     = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16,
    localparam int PHASE_W       = phase_w_f(NUM_PHASES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               phase_done,
    input  logic               phase_err,
    input  logic               mismatch,
    output logic               phase_start,
    output logic [PHASE_W-1:0] phase_id,
    output logic               busy,
    output logic               pass,
    output logic               fail,
    output logic               timeout,
`ifdef TEST_SEQ_CONTINUE_ON_FAIL_EN
    output logic [PHASE_W:0]   fail_count,
`endif
    output logic [PHASE_W-1:0] err_phase
);

    localparam logic [PHASE_W-1:0] LAST_ID = PHASE_W'(NUM_PHASES - 1);

    state_t             r_state, w_state_nxt;
    logic [PHASE_W-1:0] r_phase_id, w_phase_id_nxt;
    logic [PHASE_W-1:0] r_err_phase, w_err_phase_nxt;
    logic [1:0]         w_result;
    logic               r_phase_start, r_busy, r_pass, r_fail, r_timeout;
    logic               w_timer_expired, w_timer_clr, w_timer_en, w_in_phase;

    assign w_in_phase  = (r_state == S_START) || (r_state == S_WAIT) || (r_state == S_NEXT);
    assign w_timer_clr = (r_state != S_WAIT);
    assign w_timer_en  = (r_state == S_WAIT);

    test_seq_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_timer_clr),
        .en      (w_timer_en),
        .expired (w_timer_expired)
    );

`ifdef TEST_SEQ_CONTINUE_ON_FAIL_EN
    logic             r_mismatch_seen, r_phase_flagged;
    logic [PHASE_W:0] r_fail_count;
    logic             w_flag_now, w_new_fail;

    assign w_flag_now = w_in_phase &&
                        (mismatch || ((r_state == S_WAIT) && phase_done && phase_err));
    assign w_new_fail = w_flag_now && !r_phase_flagged;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_id_nxt  = r_phase_id;
        w_err_phase_nxt = r_err_phase;
        w_result        = RES_NONE;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt    = S_START;
                    w_phase_id_nxt = '0;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
`ifndef TEST_SEQ_CONTINUE_ON_FAIL_EN
                if (mismatch) begin
                    w_state_nxt = S_FAIL;
                    w_result    = RES_FAIL;
                end
`endif
            end
            S_WAIT: begin
`ifdef TEST_SEQ_CONTINUE_ON_FAIL_EN
                if (phase_done && (r_phase_id == LAST_ID)) begin
                    w_state_nxt = (r_mismatch_seen || w_flag_now) ? S_FAIL : S_PASS;
                    w_result    = (r_mismatch_seen || w_flag_now) ? RES_FAIL : RES_PASS;
                end else if (phase_done) begin
                    w_state_nxt = S_NEXT;
                end else if (w_timer_expired) begin
                    w_state_nxt = S_FAIL;
                    w_result    = RES_TIMEOUT;
                end
`else
                // Done on the expiry cycle is on time: timeout is checked last.
                if (mismatch || (phase_done && phase_err)) begin
                    w_state_nxt = S_FAIL;
                    w_result    = RES_FAIL;
                end else if (phase_done && (r_phase_id == LAST_ID)) begin
                    w_state_nxt = S_PASS;
                    w_result    = RES_PASS;
                end else if (phase_done) begin
                    w_state_nxt = S_NEXT;
                end else if (w_timer_expired) begin
                    w_state_nxt = S_FAIL;
                    w_result    = RES_TIMEOUT;
                end
`endif
            end
            S_NEXT: begin
                w_state_nxt    = S_START;
                w_phase_id_nxt = r_phase_id + PHASE_W'(1);
`ifndef TEST_SEQ_CONTINUE_ON_FAIL_EN
                if (mismatch) begin
                    w_state_nxt    = S_FAIL;
                    w_phase_id_nxt = r_phase_id;
                    w_result       = RES_FAIL;
                end
`endif
            end
            default: ;
        endcase

`ifdef TEST_SEQ_CONTINUE_ON_FAIL_EN
        if ((w_new_fail || (w_result == RES_TIMEOUT)) && !r_mismatch_seen) begin
            w_err_phase_nxt = r_phase_id;
        end
`else
        if ((w_result == RES_FAIL) || (w_result == RES_TIMEOUT)) begin
            w_err_phase_nxt = r_phase_id;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_phase_id    <= '0;
            r_err_phase   <= '0;
            r_phase_start <= 1'b0;
            r_busy        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase_id    <= w_phase_id_nxt;
            r_err_phase   <= w_err_phase_nxt;
            r_phase_start <= (w_state_nxt == S_START);
            r_busy        <= (w_state_nxt == S_START) || (w_state_nxt == S_WAIT) ||
                             (w_state_nxt == S_NEXT);
            r_pass        <= (w_state_nxt == S_PASS);
            r_fail        <= (w_state_nxt == S_FAIL);
            if (w_result == RES_TIMEOUT) begin
                r_timeout <= 1'b1;
            end
        end
    end

`ifdef TEST_SEQ_CONTINUE_ON_FAIL_EN
    // A mismatch in NEXT still belongs to the phase that just finished.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mismatch_seen <= 1'b0;
            r_phase_flagged <= 1'b0;
            r_fail_count    <= '0;
        end else begin
            if (w_new_fail || ((w_result == RES_TIMEOUT) && !r_phase_flagged)) begin
                r_fail_count <= r_fail_count + (PHASE_W + 1)'(1);
            end
            if (w_new_fail) begin
                r_mismatch_seen <= 1'b1;
            end
            r_phase_flagged <= (r_state == S_NEXT) ? 1'b0 : (r_phase_flagged | w_new_fail);
        end
    end

    assign fail_count = r_fail_count;
`endif

    assign phase_start = r_phase_start;
    assign phase_id    = r_phase_id;
    assign busy        = r_busy;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign err_phase   = r_err_phase;

endmodule

// File: tb/tb_test_phase_sequencer.sv
// Self-checking bench for test_phase_sequencer (default build): directed vector
// table, hand-written reset/idle sequences and random scenarios vs a timeline model.
module tb_test_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       phase_done = 1'b0;
    logic       phase_err = 1'b0;
    logic       mismatch = 1'b0;
    logic       phase_start, busy, pass, fail, timeout;
    logic [1:0] phase_id, err_phase;
`ifdef TEST_SEQ_CONTINUE_ON_FAIL_EN
    logic [2:0] fail_count;
`endif

    test_phase_sequencer #(
        .NUM_PHASES     (4),
        .TIMEOUT_CYCLES (20),
        .CNT_W          (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .phase_done  (phase_done),
        .phase_err   (phase_err),
        .mismatch    (mismatch),
        .phase_start (phase_start),
        .phase_id    (phase_id),
        .busy        (busy),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
`ifdef TEST_SEQ_CONTINUE_ON_FAIL_EN
        .fail_count  (fail_count),
`endif
        .err_phase   (err_phase)
    );

    always #5 clk = ~clk;

    // d[p]: done pulse comes d cycles after phase p's start pulse; 0 or >20 = never.
    typedef struct packed {
        logic [3:0][7:0] d;
        logic [3:0]      err;
        logic [15:0]     m;
        logic            exp_pass;
        logic            exp_fail;
        logic            exp_to;
        logic [7:0]      exp_ep;
        logic [7:0]      exp_n;
        logic [15:0]     exp_end;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    int ob_n, ob_end, ob_busy_end, ob_busy_before, ob_both;
    int ob_pass, ob_fail, ob_to, ob_ep;
    int ob_start[4];
    int ob_id[4];
    int mod_starts[4];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input int d0, input int d1, input int d2, input int d3,
                                input logic [3:0] err, input int m, input logic p,
                                input logic f, input logic t, input int ep, input int n,
                                input int endc);
        vec_t v;
        v.d        = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
        v.err      = err;
        v.m        = 16'(m);
        v.exp_pass = p;
        v.exp_fail = f;
        v.exp_to   = t;
        v.exp_ep   = 8'(ep);
        v.exp_n    = 8'(n);
        v.exp_end  = 16'(endc);
        return v;
    endfunction

    // Timeline model: enable in cycle 0, phase p starts at s, its WAIT window
    // ends at e = s + min(d,20), NEXT sits at e+1, next start at e+2.
    // Outcome is visible the cycle after the deciding cycle.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int s = 1;
        int dd, e, mm;
        mm = int'(v.m);
        r.exp_pass = 0; r.exp_fail = 0; r.exp_to = 0; r.exp_ep = 0;
        for (int p = 0; p < 4; p++) begin
            mod_starts[p] = s;
            r.exp_n = 8'(p + 1);
            dd = int'(v.d[p]);
            if (dd < 1 || dd > 20) dd = 21;
            e = s + ((dd > 20) ? 20 : dd);
            if (mm >= s && mm <= e) begin
                r.exp_fail = 1; r.exp_ep = 8'(p); r.exp_end = 16'(mm + 1); return r;
            end
            if (dd > 20) begin
                r.exp_fail = 1; r.exp_to = 1; r.exp_ep = 8'(p); r.exp_end = 16'(e + 1); return r;
            end
            if (v.err[p]) begin
                r.exp_fail = 1; r.exp_ep = 8'(p); r.exp_end = 16'(e + 1); return r;
            end
            if (p == 3) begin
                r.exp_pass = 1; r.exp_end = 16'(e + 1); return r;
            end
            if (mm == e + 1) begin
                r.exp_fail = 1; r.exp_ep = 8'(p); r.exp_end = 16'(e + 2); return r;
            end
            s = e + 2;
        end
        return r;
    endfunction

    task automatic apply_reset();
        reset = 1'b1; enable = 1'b0; phase_done = 1'b0; mismatch = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Runs one scenario; cycle c inputs are driven 1ns after posedge c and
    // outputs of cycle c are sampled on the following negedge.
    task automatic run_seq(input vec_t v, input bit do_reset, input int reset_at);
        int last_start = -100;
        int k = -1;
        int prev_busy = 0;
        int dk;
        if (do_reset) apply_reset();
        ob_n = 0; ob_end = -1; ob_busy_end = -1; ob_busy_before = -1; ob_both = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            dk = (k >= 0) ? int'(v.d[k]) : 0;
            enable     = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            phase_done = (k >= 0) && (dk >= 1) && (dk <= 20) && (c == last_start + dk);
            phase_err  = phase_done ? v.err[k] : 1'($urandom_range(0, 1));
            mismatch   = (c == int'(v.m));
            reset      = (reset_at >= 0) && (c == reset_at);
            if (reset_at >= 0 && c == reset_at + 1) begin
                reset = 1'b0; enable = 1'b0; phase_done = 1'b0; mismatch = 1'b0;
                @(negedge clk);
                check("rst_phase_start", int'(phase_start), 0);
                check("rst_phase_id", int'(phase_id), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_pass_fail", int'({pass, fail}), 0);
                check("rst_timeout", int'(timeout), 0);
                check("rst_err_phase", int'(err_phase), 0);
                return;
            end
            @(negedge clk);
            if (phase_start) begin
                if (ob_n < 4) begin
                    ob_start[ob_n] = c;
                    ob_id[ob_n]    = int'(phase_id);
                end
                ob_n++;
                last_start = c;
                k = (ob_n > 4) ? 3 : ob_n - 1;
            end
            if (pass && fail) ob_both = 1;
            if ((pass || fail) && ob_end < 0) begin
                ob_end = c; ob_busy_end = int'(busy); ob_busy_before = prev_busy;
            end
            prev_busy = int'(busy);
            if (ob_end >= 0 && c >= ob_end + 3) break;
        end
        ob_pass = int'(pass); ob_fail = int'(fail); ob_to = int'(timeout); ob_ep = int'(err_phase);
        phase_done = 1'b0; mismatch = 1'b0; enable = 1'b0;
    endtask

    task automatic check_run(input string tag, input vec_t v, input bit chk_starts);
        int lim;
        check({tag, "_pass"}, ob_pass, int'(v.exp_pass));
        check({tag, "_fail"}, ob_fail, int'(v.exp_fail));
        check({tag, "_timeout"}, ob_to, int'(v.exp_to));
        check({tag, "_err_phase"}, ob_ep, int'(v.exp_ep));
        check({tag, "_nstarts"}, ob_n, int'(v.exp_n));
        check({tag, "_end_cycle"}, ob_end, int'(v.exp_end));
        check({tag, "_busy_at_end"}, ob_busy_end, 0);
        check({tag, "_busy_before_end"}, ob_busy_before, 1);
        check({tag, "_pass_and_fail"}, ob_both, 0);
        lim = (ob_n < 4) ? ob_n : 4;
        for (int i = 0; i < lim; i++) begin
            check($sformatf("%s_id%0d", tag, i), ob_id[i], i);
            if (chk_starts) check($sformatf("%s_start%0d", tag, i), ob_start[i], mod_starts[i]);
        end
    endtask

    vec_t vecs[11];
    vec_t rv;
    int   quiet_bad;

    initial begin
        //              d0  d1  d2  d3  err      m    p  f  t  ep n  end
        vecs[0]  = mk(10, 10, 10, 10, 4'b0000, 999, 1, 0, 0, 0, 4, 48);
        vecs[1]  = mk(10, 10, 10, 10, 4'b0100, 999, 0, 1, 0, 2, 3, 36);
        vecs[2]  = mk(10,  0, 10, 10, 4'b0000, 999, 0, 1, 1, 1, 2, 34);
        vecs[3]  = mk(10, 20, 10, 10, 4'b0000, 999, 1, 0, 0, 0, 4, 58);
        vecs[4]  = mk(10, 10, 10, 10, 4'b0000,  12, 0, 1, 0, 0, 1, 13);
        vecs[5]  = mk(10, 10, 10, 10, 4'b0000,  11, 0, 1, 0, 0, 1, 12);
        vecs[6]  = mk( 1,  1,  1,  1, 4'b0000, 999, 1, 0, 0, 0, 4, 12);
        vecs[7]  = mk( 1,  1,  1,  1, 4'b0000,  10, 0, 1, 0, 3, 4, 11);
        vecs[8]  = mk(20, 10, 10, 10, 4'b0001, 999, 0, 1, 0, 0, 1, 22);
        vecs[9]  = mk( 0, 10, 10, 10, 4'b0000, 999, 0, 1, 1, 0, 1, 22);
        vecs[10] = mk( 1,  1,  1,  1, 4'b0000,   0, 1, 0, 0, 0, 4, 12);

        apply_reset();
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_outputs", int'({phase_start, pass, fail, timeout, phase_id, err_phase}), 0);

        for (int i = 0; i < 11; i++) begin
            run_seq(vecs[i], 1'b1, -1);
            check_run($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        // Reset in phase 2 WAIT, then a clean rerun without further reset.
        apply_reset();
        run_seq(vecs[0], 1'b0, 30);
        run_seq(vecs[0], 1'b0, -1);
        check_run("rerun", vecs[0], 1'b0);

        // Idle with enable low: spurious done/err/mismatch must not start anything.
        apply_reset();
        quiet_bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            enable     = 1'b0;
            phase_done = 1'($urandom_range(0, 1));
            phase_err  = 1'($urandom_range(0, 1));
            mismatch   = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (busy || phase_start || pass || fail) quiet_bad++;
        end
        phase_done = 1'b0; mismatch = 1'b0;
        check("idle_quiet", quiet_bad, 0);

        for (int r = 0; r < 40; r++) begin
            rv = '0;
            for (int p = 0; p < 4; p++) begin
                rv.d[p]   = ($urandom_range(0, 9) == 0) ? 8'(21 + $urandom_range(0, 1))
                                                        : 8'($urandom_range(1, 20));
                rv.err[p] = ($urandom_range(0, 7) == 0);
            end
            rv.m = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 90)) : 16'd999;
            rv = model(rv);
            run_seq(rv, 1'b1, -1);
            check_run($sformatf("rnd%0d", r), rv, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/test_phase_sequencer.md
Name: test_phase_sequencer

Overview:
- Synthesizable bench-side controller that drives a DUT test through NUM_PHASES ordered phases.
- Per phase: issues a start pulse, waits for done under a cycle timeout, and folds in checker errors.
- Drives one pass or one fail outcome into the bench's test-status monitor.
- Sits between the per-phase stimulus drivers/checkers and the status monitor. It is the only source of the monitor's pass/fail inputs.

Parameters:
- NUM_PHASES, 4: number of sequenced phases; range 1..256.
- TIMEOUT_CYCLES, 1000: maximum cycles spent in WAIT per phase; must be ≥1.
- CNT_W, 16: timer width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- Derived localparam PHASE_W = max(1, clog2(NUM_PHASES)).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  start request, level-sampled in IDLE only
- phase_done  in  1  current phase finished; single-cycle pulse
- phase_err  in  1  phase result error; valid only when phase_done=1
- mismatch  in  1  checker data mismatch; may assert in any cycle
- phase_start  out  1  one-cycle pulse that launches phase phase_id
- phase_id  out  PHASE_W  current phase index
- busy  out  1  high in START/WAIT/NEXT
- pass  out  1  all phases clean; sticky until reset
- fail  out  1  failure detected; sticky until reset
- timeout  out  1  failure cause was timeout; sticky
- err_phase  out  PHASE_W  phase index of the first failure

Behaviour:
- Reset values:
  - Outputs: all 0.
  - State: IDLE.
  - Internal: timer 0; mismatch_seen 0.
- Reset asserted mid-sequence aborts in the next cycle and clears all state, including the sticky flags.
- All outputs are registered.
- FSM states: IDLE, START, WAIT, NEXT, PASS, FAIL.
- IDLE: if enable=1, go to START with phase_id=0.
- START: phase_start=1 for exactly this cycle; timer cleared; go to WAIT.
- WAIT: timer increments by 1 each cycle. Evaluate in this priority order:
  1. mismatch=1 → FAIL; err_phase=phase_id.
  2. phase_done=1 and phase_err=1 → FAIL; err_phase=phase_id.
  3. phase_done=1, phase_id==NUM_PHASES-1 → PASS.
  4. phase_done=1 otherwise → NEXT.
  5. timer==TIMEOUT_CYCLES-1 → FAIL; timeout=1; err_phase=phase_id.
- Consequence of the priority order: phase_done in the same cycle as timer expiry counts as on time.
- NEXT: phase_id += 1; go to START. This gives one idle cycle between phases.
- mismatch in START or NEXT also forces FAIL, with err_phase = the current phase_id.
- PASS and FAIL are terminal:
  - pass/fail rise 1 cycle after the deciding input and hold until reset.
  - pass and fail are never both 1.
  - busy=0 in both.
- enable is ignored outside IDLE. Deasserting it mid-sequence has no effect.
- phase_done outside WAIT is ignored.
- Latency for NUM_PHASES=1 with done on the first WAIT cycle: enable@0 → START@1 → WAIT@2 → pass@3.

Optional Feature:
- Macro: TEST_SEQ_CONTINUE_ON_FAIL_EN.
- Defined:
  - phase_err and mismatch do not stop the sequence. The sequence still runs through the last phase.
  - err_phase latches the first failing phase.
  - A sticky internal flag selects FAIL instead of PASS at the end.
  - Timeout still terminates immediately into FAIL.
  - An extra output fail_count [PHASE_W:0] counts failing phases, at most one increment per phase. Reset value 0.
- Undefined: behaviour as above; no fail_count port.

Decomposition:
- Package test_seq_pkg contains:
  - the state enum (IDLE..FAIL);
  - a clog2-based PHASE_W helper function;
  - result-code constants.
- Sub-module test_seq_timer:
  - CNT_W counter with clear and enable inputs;
  - expired output = (count == TIMEOUT_CYCLES-1);
  - instantiated once.

Test Plan:
- NUM_PHASES=4, each phase_done 10 cycles after phase_start, phase_err=0 → four phase_start pulses with phase_id 0,1,2,3; pass=1, fail=0; busy falls in the same cycle pass rises.
- phase_err=1 with phase_done in phase 2 → fail=1, err_phase=2, timeout=0, no phase_start for phase 3. Macro defined: sequence reaches phase 3, then fail=1, fail_count=1.
- TIMEOUT_CYCLES=20, phase 1 never done → fail=1, timeout=1, err_phase=1 exactly 20 cycles after phase 1's WAIT entry. Separately, done on cycle 20 → no timeout, sequence proceeds.
- mismatch pulse in the NEXT cycle after phase 0 → fail=1, err_phase=0. Separately, mismatch and phase_done with phase_err=0 in the same cycle → fail wins.
- reset asserted during phase 2 WAIT → next cycle: all outputs 0, state IDLE. Re-enable → full clean run to pass=1.
- enable held low for 50 cycles, spurious phase_done pulses in IDLE → busy, phase_start, pass and fail all remain 0.
